hazard_stall_controller: RTL and testbench

- Pipeline control unit for the 5-stage MIPS-lite pipeline without forwarding (IF, ID, EX, MEM, WB).
- Keeps its own scoreboard of destination registers in flight in EX, MEM and WB.
- Detects RAW hazards against the instruction in ID and stalls IF/ID until the producer reaches WB.
- Squashes IF/ID on a taken branch or JR resolved in EX, sequences HALT drain, and owns the run-statistics counters.

---
 rtl/hazard_stall_if.sv | 38 +++
 rtl/hazard_stall_controller.sv | 127 ++++++++++++
 tb/tb_hazard_stall_controller.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_if.sv
// ID-stage instruction fields and branch resolve in; pipeline control and
// run statistics out.
interface hazard_stall_if #(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
);
  localparam int RW = $clog2(NREG);

  logic             id_valid;
  logic [5:0]       id_opcode;
  logic [RW-1:0]    id_rs;
  logic [RW-1:0]    id_rt;
  logic [RW-1:0]    id_rd;
  logic             ex_branch_taken;

  logic             fetch_en;
  logic             if_stall;
  logic             id_stall;
  logic             flush;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] raw_events;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] retired;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, ex_branch_taken,
    input  fetch_en, if_stall, id_stall, flush, halted,
           cycle_count, stall_cycles, raw_events, flush_count, retired
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, ex_branch_taken,
    output fetch_en, if_stall, id_stall, flush, halted,
           cycle_count, stall_cycles, raw_events, flush_count, retired
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// RAW-hazard stall, branch flush and HALT drain control for a 5-stage
// pipeline without forwarding, with saturating run statistics.
module hazard_stall_controller #(
  parameter int NREG    = 32,
  parameter int CNT_W   = 32,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_stall_if.slave hs
);
  localparam int RW = $clog2(NREG);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] dst;
    logic          has_dst;
    logic          is_halt;
  } slot_t;

  state_t state, state_nxt;
  slot_t [2:0] sb;  // 0 = EX, 1 = MEM, 2 = WB
  slot_t id_slot;

  logic          id_vld, use_rs, use_rt, hazard, advance;
  logic          fetch_en, halted, flush, stall;
  logic          prev_stall;
  logic [5+3*RW-1:0] prev_key, id_key;
  logic [CNT_W-1:0] cnt_cycle, cnt_stall, cnt_raw, cnt_flush, cnt_ret;

  function automatic logic hit(input slot_t s, input logic [RW-1:0] r);
    return s.valid && s.has_dst && (s.dst == r) && !(R0_ZERO && (r == '0));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + ONE : v;
  endfunction

  // Decode; ID is ignored outside RUN so drain injects bubbles.
  always_comb begin
    id_vld  = hs.id_valid && (state == RUN) && (hs.id_opcode <= 6'd17);
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    id_slot = '0;
    id_slot.dst = hs.id_rd;
    if (hs.id_opcode <= 6'd11) begin
      use_rs          = 1'b1;
      use_rt          = !hs.id_opcode[0];
      id_slot.has_dst = 1'b1;
      id_slot.dst     = hs.id_opcode[0] ? hs.id_rt : hs.id_rd;
    end else begin
      unique case (hs.id_opcode)
        6'd12: begin use_rs = 1'b1; id_slot.has_dst = 1'b1; id_slot.dst = hs.id_rt; end
        6'd13, 6'd15: begin use_rs = 1'b1; use_rt = 1'b1; end
        6'd14, 6'd16: use_rs = 1'b1;
        6'd17: id_slot.is_halt = 1'b1;
        default: ;
      endcase
    end
    id_slot.valid = id_vld;
    hazard = id_vld &&
             ((use_rs && (hit(sb[0], hs.id_rs) || hit(sb[1], hs.id_rs))) ||
              (use_rt && (hit(sb[0], hs.id_rt) || hit(sb[1], hs.id_rt))));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (advance && id_slot.is_halt) state_nxt = DRAIN;
      DRAIN:   if (sb[2].valid && sb[2].is_halt) state_nxt = HALTED;
      default: state_nxt = HALTED;
    endcase
  end

  always_comb begin
    fetch_en = (state == RUN);
    halted   = (state == HALTED);
    flush    = hs.ex_branch_taken && !halted;
    stall    = hazard && !flush;
    advance  = id_vld && !stall && !flush;
  end

  assign id_key = {hs.id_opcode, hs.id_rs, hs.id_rt, hs.id_rd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb         <= '0;
      prev_stall <= 1'b0;
      prev_key   <= '0;
      cnt_cycle  <= '0;
      cnt_stall  <= '0;
      cnt_raw    <= '0;
      cnt_flush  <= '0;
      cnt_ret    <= '0;
    end else if (!halted) begin
      sb[2]      <= sb[1];
      sb[1]      <= sb[0];
      sb[0]      <= advance ? id_slot : '0;
      prev_stall <= stall;
      prev_key   <= id_key;
      cnt_cycle  <= sat_inc(cnt_cycle, 1'b1);
      cnt_stall  <= sat_inc(cnt_stall, stall);
      // A new stall episode, or a different instruction stalling back to back.
      cnt_raw    <= sat_inc(cnt_raw, stall && (!prev_stall || (prev_key != id_key)));
      cnt_flush  <= sat_inc(cnt_flush, flush);
      cnt_ret    <= sat_inc(cnt_ret, sb[2].valid);
    end
  end

  assign hs.fetch_en     = fetch_en;
  assign hs.halted       = halted;
  assign hs.flush        = flush;
  assign hs.id_stall     = stall;
  assign hs.if_stall     = stall;
  assign hs.cycle_count  = cnt_cycle;
  assign hs.stall_cycles = cnt_stall;
  assign hs.raw_events   = cnt_raw;
  assign hs.flush_count  = cnt_flush;
  assign hs.retired      = cnt_ret;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench for hazard_stall_controller with hand-computed expectations.
module tb_hazard_stall_controller;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  hazard_stall_if #(.NREG(32), .CNT_W(32)) hs ();

  hazard_stall_controller #(.NREG(32), .CNT_W(32), .R0_ZERO(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hs    (hs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic put(input logic v, input logic [5:0] op, input logic [4:0] rs, rt, rd,
                     input logic br);
    hs.id_valid        = v;
    hs.id_opcode       = op;
    hs.id_rs           = rs;
    hs.id_rt           = rt;
    hs.id_rd           = rd;
    hs.ex_branch_taken = br;
    #1;
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic bub();
    put(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Reset pulse inside the low clock phase; caller drives before the next rise.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bub();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic t_raw(input string p);
    do_reset();
    put(1'b1, 6'd0, 5'd2, 5'd3, 5'd1, 1'b0);  // ADD r1,r2,r3
    chk({p, ".first"}, hs.id_stall, 0);
    nxt();
    put(1'b1, 6'd0, 5'd1, 5'd5, 5'd4, 1'b0);  // ADD r4,r1,r5
    chk({p, ".stall1"}, hs.id_stall, 1);
    chk({p, ".ifstall1"}, hs.if_stall, 1);
    nxt();
    chk({p, ".stall2"}, hs.id_stall, 1);
    nxt();
    chk({p, ".go"}, hs.id_stall, 0);
    nxt();
    bub();
    chk({p, ".cycles"}, hs.cycle_count, 4);
    chk({p, ".stall_cyc"}, hs.stall_cycles, 2);
    chk({p, ".raw"}, hs.raw_events, 1);
    chk({p, ".retired"}, hs.retired, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    bub();
    #2;
    chk("rst.fetch_en", hs.fetch_en, 1);
    chk("rst.id_stall", hs.id_stall, 0);
    chk("rst.flush", hs.flush, 0);
    chk("rst.halted", hs.halted, 0);
    chk("rst.cycles", hs.cycle_count, 0);
    chk("rst.retired", hs.retired, 0);

    t_raw("raw");

    // distance 2 -> one stall cycle
    do_reset();
    put(1'b1, 6'd1, 5'd0, 5'd1, 5'd0, 1'b0);  // ADDI r1,r0,5
    nxt();
    put(1'b1, 6'd6, 5'd8, 5'd9, 5'd7, 1'b0);  // OR r7,r8,r9
    chk("d2.or", hs.id_stall, 0);
    nxt();
    put(1'b1, 6'd2, 5'd1, 5'd2, 5'd6, 1'b0);  // SUB r6,r1,r2
    chk("d2.stall", hs.id_stall, 1);
    nxt();
    chk("d2.go", hs.id_stall, 0);
    nxt();
    bub();
    chk("d2.stall_cyc", hs.stall_cycles, 1);

    // distance 3 -> no stall
    do_reset();
    put(1'b1, 6'd1, 5'd0, 5'd1, 5'd0, 1'b0);
    nxt();
    put(1'b1, 6'd6, 5'd8, 5'd9, 5'd7, 1'b0);
    nxt();
    put(1'b1, 6'd10, 5'd11, 5'd12, 5'd10, 1'b0);
    nxt();
    put(1'b1, 6'd2, 5'd1, 5'd2, 5'd6, 1'b0);
    chk("d3.nostall", hs.id_stall, 0);
    nxt();
    bub();
    chk("d3.stall_cyc", hs.stall_cycles, 0);

    // STW on rt behind LDW
    do_reset();
    put(1'b1, 6'd12, 5'd9, 5'd7, 5'd0, 1'b0);  // LDW r7,0(r9)
    nxt();
    put(1'b1, 6'd13, 5'd8, 5'd7, 5'd0, 1'b0);  // STW r7,0(r8)
    chk("stw.stall1", hs.id_stall, 1);
    nxt();
    chk("stw.stall2", hs.id_stall, 1);
    nxt();
    chk("stw.go", hs.id_stall, 0);

    // BZ behind SUBI
    do_reset();
    put(1'b1, 6'd3, 5'd4, 5'd3, 5'd0, 1'b0);   // SUBI r3,r4,#
    nxt();
    put(1'b1, 6'd14, 5'd3, 5'd0, 5'd0, 1'b0);  // BZ r3
    chk("bz.stall1", hs.id_stall, 1);
    nxt();
    chk("bz.stall2", hs.id_stall, 1);
    nxt();
    chk("bz.go", hs.id_stall, 0);

    // R0 writes are tracked when R0_ZERO=0
    do_reset();
    put(1'b1, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);   // ADD r0,r1,r2
    nxt();
    put(1'b1, 6'd0, 5'd0, 5'd0, 5'd5, 1'b0);   // ADD r5,r0,r0
    chk("r0.stall", hs.id_stall, 1);

    // taken BEQ in EX squashes hazarded ADD in ID
    do_reset();
    put(1'b1, 6'd0, 5'd2, 5'd3, 5'd1, 1'b0);   // ADD r1,r2,r3
    nxt();
    put(1'b1, 6'd15, 5'd4, 5'd5, 5'd0, 1'b0);  // BEQ r4,r5
    nxt();
    put(1'b1, 6'd0, 5'd1, 5'd2, 5'd6, 1'b1);   // ADD r6,r1,r2 + taken
    chk("br.flush", hs.flush, 1);
    chk("br.nostall", hs.id_stall, 0);
    chk("br.noifstall", hs.if_stall, 0);
    nxt();
    bub();
    chk("br.flush_cnt", hs.flush_count, 1);
    nxt();
    nxt();
    nxt();
    chk("br.retired", hs.retired, 2);
    chk("br.stall_cyc", hs.stall_cycles, 0);

    // HALT drain
    do_reset();
    put(1'b1, 6'd0, 5'd2, 5'd3, 5'd1, 1'b0);
    nxt();
    put(1'b1, 6'd0, 5'd5, 5'd6, 5'd4, 1'b0);
    nxt();
    put(1'b1, 6'd0, 5'd8, 5'd9, 5'd7, 1'b0);
    nxt();
    put(1'b1, 6'd0, 5'd11, 5'd12, 5'd10, 1'b0);
    nxt();
    put(1'b1, 6'd17, 5'd0, 5'd0, 5'd0, 1'b0);  // HALT
    chk("halt.fetch_before", hs.fetch_en, 1);
    nxt();
    put(1'b1, 6'd0, 5'd10, 5'd1, 5'd13, 1'b0); // ignored while draining
    chk("halt.fetch_off", hs.fetch_en, 0);
    chk("halt.drain_nostall", hs.id_stall, 0);
    nxt();
    bub();
    nxt();
    chk("halt.not_yet", hs.halted, 0);
    nxt();
    chk("halt.halted", hs.halted, 1);
    chk("halt.fetch", hs.fetch_en, 0);
    chk("halt.retired", hs.retired, 5);
    chk("halt.cycles", hs.cycle_count, 8);
    put(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    chk("halt.noflush", hs.flush, 0);
    nxt();
    nxt();
    nxt();
    chk("halt.frozen", hs.cycle_count, 8);
    chk("halt.stays", hs.halted, 1);

    // reset during the second stall cycle, then rerun
    do_reset();
    put(1'b1, 6'd0, 5'd2, 5'd3, 5'd1, 1'b0);
    nxt();
    put(1'b1, 6'd0, 5'd1, 5'd5, 5'd4, 1'b0);
    nxt();
    chk("mid.stall2", hs.id_stall, 1);
    rst_n = 1'b0;
    #1;
    chk("mid.id_stall", hs.id_stall, 0);
    chk("mid.fetch_en", hs.fetch_en, 1);
    chk("mid.cycles", hs.cycle_count, 0);
    chk("mid.stall_cyc", hs.stall_cycles, 0);
    t_raw("rerun");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
